// File: rtl/spi_cmd_queue_if.sv
// Host command/response and spi_ctrl command bus for spi_cmd_queue.
// slave = the queue, master = the host / spi_ctrl side.
interface spi_cmd_queue_if;
    logic [23:0] cmd_in;
    logic        cmd_in_valid;
    logic        cmd_in_ready;
    logic [7:0]  rsp_data;
    logic [14:0] rsp_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [23:0] ctrl_cmd_data;
    logic        ctrl_ready;
    logic        ctrl_en;
    logic [7:0]  ctrl_read_data;
    logic        ctrl_sink_vld;

    modport slave (
        input  cmd_in, cmd_in_valid, rsp_ready, ctrl_read_data, ctrl_sink_vld,
        output cmd_in_ready, rsp_data, rsp_addr, rsp_valid,
               ctrl_cmd_data, ctrl_ready, ctrl_en
    );

    modport master (
        output cmd_in, cmd_in_valid, rsp_ready, ctrl_read_data, ctrl_sink_vld,
        input  cmd_in_ready, rsp_data, rsp_addr, rsp_valid,
               ctrl_cmd_data, ctrl_ready, ctrl_en
    );
endinterface

// File: rtl/spi_cmd_queue.sv
// Command FIFO and one-at-a-time issue scheduler in front of spi_ctrl.
// Optional WAIT timeout is enabled by defining SPI_CMD_QUEUE_TIMEOUT_EN.
module spi_cmd_queue #(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    spi_cmd_queue_if.slave         bus,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy,
    output logic                   timeout_err,
    input  logic                   err_clr
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state;
    logic [23:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [23:0] head;
    logic        is_read;
    logic [14:0] addr;
    logic        full;
    logic        empty;
    logic        push;

    // Extra pointer bit separates full (MSBs differ) from empty (pointers equal).
    assign full             = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty            = (wr_ptr == rd_ptr);
    assign level            = wr_ptr - rd_ptr;
    assign push             = bus.cmd_in_valid && !full;
    assign bus.cmd_in_ready = !full;
    assign head             = mem[rd_ptr[AW-1:0]];
    assign busy             = (state != IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= bus.cmd_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
        end
    end

`ifdef SPI_CMD_QUEUE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;
    logic          timeout_hit;

    assign timeout_hit = (state == WAIT) && !bus.ctrl_sink_vld &&
                         (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    // A new timeout takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err <= 1'b0;
        end else if (timeout_hit) begin
            timeout_err <= 1'b1;
        end else if (err_clr) begin
            timeout_err <= 1'b0;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg  = err_clr ^ (TIMEOUT_CYCLES == 0);
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            rd_ptr            <= '0;
            is_read           <= 1'b0;
            addr              <= '0;
            bus.ctrl_cmd_data <= '0;
            bus.ctrl_ready    <= 1'b0;
            bus.ctrl_en       <= 1'b0;
            bus.rsp_valid     <= 1'b0;
            bus.rsp_data      <= '0;
            bus.rsp_addr      <= '0;
`ifdef SPI_CMD_QUEUE_TIMEOUT_EN
            wait_cnt          <= '0;
`endif
        end else begin
            bus.ctrl_en <= 1'b1;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        bus.ctrl_cmd_data <= head;
                        is_read           <= !head[23];
                        addr              <= head[22:8];
                        rd_ptr            <= rd_ptr + 1'b1;
                        bus.ctrl_ready    <= 1'b1;
                        state             <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.ctrl_ready <= 1'b0;
                    state          <= WAIT;
`ifdef SPI_CMD_QUEUE_TIMEOUT_EN
                    wait_cnt       <= '0;
`endif
                end
                WAIT: begin
                    if (bus.ctrl_sink_vld) begin
                        if (is_read) begin
                            bus.rsp_data  <= bus.ctrl_read_data;
                            bus.rsp_addr  <= addr;
                            bus.rsp_valid <= 1'b1;
                            state         <= RESP;
                        end else begin
                            state <= IDLE;
                        end
                    end
`ifdef SPI_CMD_QUEUE_TIMEOUT_EN
                    // A timed-out read still answers the host, with all-ones data.
                    else if (timeout_hit) begin
                        if (is_read) begin
                            bus.rsp_data  <= 8'hFF;
                            bus.rsp_addr  <= addr;
                            bus.rsp_valid <= 1'b1;
                            state         <= RESP;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
`endif
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
